// File: rtl/sdram_rd_return.sv
// rtl/sdram_rd_return.sv - SDRAM read return path: CL-matched tag pipe, burst capture, FWFT output FIFO
//
// Tracks each issued read through a CAS-latency tag pipeline, captures the
// BL-word burst from DQ, and buffers it in a first-word-fall-through FIFO.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   i_cl            CAS latency (2..CL_MAX), sampled only while idle
//   i_rd_issue      read command issued to the SDRAM this cycle
//   i_rd_tag        tag of the issued read
//   o_rd_allow      a new read may be issued this cycle (FIFO credit)
//   i_dq_in         SDRAM DQ input bus
//   o_out_valid     output word available (FIFO non-empty)
//   o_out_data      output word
//   o_out_tag       tag of the burst owning o_out_data
//   o_out_last      final word of a burst
//   i_out_ready     consumer accepts word when o_out_valid && i_out_ready
//   o_busy          read in flight or FIFO non-empty
//   o_protocol_err  sticky: an illegal i_rd_issue was seen
module sdram_rd_return #(
  parameter int DW     = 16,
  parameter int TW     = 4,
  parameter int BL     = 4,
  parameter int CL_MAX = 3,
  parameter int AW     = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    i_cl,
  input  logic          i_rd_issue,
  input  logic [TW-1:0] i_rd_tag,
  output logic          o_rd_allow,
  input  logic [DW-1:0] i_dq_in,
  output logic          o_out_valid,
  output logic [DW-1:0] o_out_data,
  output logic [TW-1:0] o_out_tag,
  output logic          o_out_last,
  input  logic          i_out_ready,
  output logic          o_busy,
  output logic          o_protocol_err
);

  localparam int DEPTH = 2 ** AW;
  localparam int SW    = AW + 3;          // wide enough for count + inflight + BL
  localparam int CNTW  = $clog2(BL + 1);  // holds 0..BL
  localparam int EW    = DW + TW + 1;     // FIFO entry {last, tag, data}

  // Latency and tag pipeline
  logic [1:0]      r_cl;
  logic [CL_MAX:1] r_pipe_v;
  logic [TW-1:0]   r_pipe_tag [CL_MAX:1];

  // Burst capture
  logic            r_act;
  logic [CNTW-1:0] r_cnt;
  logic [TW-1:0]   r_cur_tag;
  logic            r_dq_v;
  logic [DW-1:0]   r_dq;
  logic [TW-1:0]   r_dq_tag;
  logic            r_dq_last;

  // Issue bookkeeping
  logic [CNTW-1:0] r_since;
  logic [AW:0]     r_rd_out;
  logic            r_perr;

  // FIFO
  logic [EW-1:0]   r_mem [DEPTH];
  logic [AW:0]     r_wptr;
  logic [AW:0]     r_rptr;

  logic [1:0]      w_cl_ld;
  logic            w_fire;
  logic [TW-1:0]   w_fire_tag;
  logic            w_cap;
  logic [CNTW-1:0] w_idx;
  logic [TW-1:0]   w_cap_tag;
  logic            w_cap_last;
  logic            w_space_ok;
  logic            w_allow;
  logic            w_accept;
  logic            w_done;
  logic            w_push;
  logic            w_pop;
  logic [AW:0]     w_count;
  logic            w_empty;
  logic            w_busy;
  logic [SW-1:0]   w_sum;
  logic [EW-1:0]   w_head;

  // Out-of-range latencies are clamped so a marker always reaches a tap.
  always_comb begin
    w_cl_ld = i_cl;
    if (int'(i_cl) < 2)           w_cl_ld = 2'd2;
    else if (int'(i_cl) > CL_MAX) w_cl_ld = 2'(CL_MAX);
  end

  // Tap selection: the stage matching the latency fires this cycle.
  always_comb begin
    w_fire     = 1'b0;
    w_fire_tag = '0;
    for (int k = 1; k <= CL_MAX; k++) begin
      if (int'(r_cl) == k) begin
        w_fire     = r_pipe_v[k];
        w_fire_tag = r_pipe_tag[k];
      end
    end
  end

  // A fire is word 0 of the window; the counter covers words 1..BL-1.
  // Fire takes priority so an exactly-BL-spaced burst follows with no bubble.
  assign w_cap      = w_fire || r_act;
  assign w_idx      = w_fire ? '0 : r_cnt;
  assign w_cap_tag  = w_fire ? w_fire_tag : r_cur_tag;
  assign w_cap_last = (w_idx == CNTW'(BL - 1));

  assign w_count = r_wptr - r_rptr;
  assign w_empty = (w_count == '0);
  assign w_push  = r_dq_v;
  assign w_pop   = !w_empty && i_out_ready;
  assign w_done  = r_dq_v && r_dq_last;

  // Credit: a read holds BL slots from issue until its last word is written.
  assign w_sum      = SW'(w_count) + SW'(r_rd_out) * SW'(BL) + SW'(BL);
  assign w_allow    = (w_sum <= SW'(DEPTH));
  assign w_space_ok = (r_since >= CNTW'(BL));
  assign w_accept   = i_rd_issue && w_allow && w_space_ok;

  assign w_busy = (|r_pipe_v) || r_act || r_dq_v || !w_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cl      <= 2'd2;
      r_pipe_v  <= '0;
      for (int k = 1; k <= CL_MAX; k++) r_pipe_tag[k] <= '0;
      r_act     <= 1'b0;
      r_cnt     <= '0;
      r_cur_tag <= '0;
      r_dq_v    <= 1'b0;
      r_dq      <= '0;
      r_dq_tag  <= '0;
      r_dq_last <= 1'b0;
      r_since   <= CNTW'(BL);
      r_rd_out  <= '0;
      r_perr    <= 1'b0;
      r_wptr    <= '0;
      r_rptr    <= '0;
    end else begin
      // In-flight reads keep the latency they were issued with.
      if (!w_busy) r_cl <= w_cl_ld;

      r_pipe_v[1]   <= w_accept;
      r_pipe_tag[1] <= i_rd_tag;
      for (int k = 2; k <= CL_MAX; k++) begin
        r_pipe_v[k]   <= r_pipe_v[k-1];
        r_pipe_tag[k] <= r_pipe_tag[k-1];
      end

      if (w_fire) begin
        r_cur_tag <= w_fire_tag;
        r_cnt     <= CNTW'(1);
        r_act     <= 1'b1;
      end else if (r_act) begin
        r_cnt <= r_cnt + CNTW'(1);
        if (r_cnt == CNTW'(BL - 1)) r_act <= 1'b0;
      end

      r_dq_v <= w_cap;
      if (w_cap) begin
        r_dq      <= i_dq_in;
        r_dq_tag  <= w_cap_tag;
        r_dq_last <= w_cap_last;
      end

      if (w_accept)              r_since <= CNTW'(1);
      else if (!w_space_ok)      r_since <= r_since + CNTW'(1);

      if (i_rd_issue && !w_accept) r_perr <= 1'b1;

      case ({w_accept, w_done})
        2'b10:   r_rd_out <= r_rd_out + 1'b1;
        2'b01:   r_rd_out <= r_rd_out - 1'b1;
        default: r_rd_out <= r_rd_out;
      endcase

      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage needs no reset: the empty flag gates every read of it.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= {r_dq_last, r_dq_tag, r_dq};
  end

  assign w_head = r_mem[r_rptr[AW-1:0]];

  assign o_rd_allow     = w_allow;
  assign o_out_valid    = !w_empty;
  assign o_out_data     = w_empty ? '0 : w_head[DW-1:0];
  assign o_out_tag      = w_empty ? '0 : w_head[DW+TW-1:DW];
  assign o_out_last     = w_empty ? 1'b0 : w_head[EW-1];
  assign o_busy         = w_busy;
  assign o_protocol_err = r_perr;

endmodule

// File: tb/tb_sdram_rd_return.sv
// tb/tb_sdram_rd_return.sv - self-checking bench for sdram_rd_return
module tb_sdram_rd_return;

  localparam int BL    = 4;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  cl = 2'd2;
  logic        rd_issue = 1'b0;
  logic [3:0]  rd_tag = '0;
  logic        rd_allow;
  logic [15:0] dq_in = '0;
  logic        out_valid;
  logic [15:0] out_data;
  logic [3:0]  out_tag;
  logic        out_last;
  logic        out_ready = 1'b0;
  logic        busy;
  logic        protocol_err;

  sdram_rd_return dut (
    .clk(clk), .rst(rst), .i_cl(cl), .i_rd_issue(rd_issue), .i_rd_tag(rd_tag),
    .o_rd_allow(rd_allow), .i_dq_in(dq_in), .o_out_valid(out_valid),
    .o_out_data(out_data), .o_out_tag(out_tag), .o_out_last(out_last),
    .i_out_ready(out_ready), .o_busy(busy), .o_protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  // Reference model: timeline of accepted reads and the words they produce.
  typedef struct { int t; int lat; } rd_t;
  typedef struct { int vis; int cap; logic [3:0] tag; logic last; } wd_t;

  rd_t         m_rds[$];
  wd_t         m_wds[$];
  logic [15:0] dq_hist [int];
  int          m_lat;
  bit          m_err;
  int          m_last_acc;
  int          cyc;

  logic [24:0] obs_vec, exp_vec;
  logic        s_valid, s_last, s_allow, s_busy, s_err;
  logic [15:0] s_data;
  logic [3:0]  s_tag;

  int checks = 0;
  int failures = 0;

  task automatic model_clear();
    m_rds.delete();
    m_wds.delete();
    dq_hist.delete();
    m_lat      = 2;
    m_err      = 1'b0;
    m_last_acc = -100;
    cyc        = 0;
  endtask

  // One clock cycle: drive inputs, sample DUT and model at negedge, advance model.
  task automatic step(input logic iss, input logic [3:0] tg, input logic [1:0] clv,
                      input logic rdy, input logic [15:0] dqv);
    int fifo_cnt, inflt, lat;
    logic ev, el, ea, eb, acc;
    logic [15:0] ed;
    logic [3:0] et;
    rd_issue = iss; rd_tag = tg; cl = clv; out_ready = rdy; dq_in = dqv;
    dq_hist[cyc] = dqv;
    @(negedge clk);
    fifo_cnt = 0;
    foreach (m_wds[i]) if (m_wds[i].vis <= cyc) fifo_cnt++;
    inflt = 0;
    foreach (m_rds[i]) if (cyc <= m_rds[i].t + m_rds[i].lat + BL) inflt++;
    ea = (fifo_cnt + BL * inflt + BL) <= DEPTH;
    eb = (inflt > 0) || (fifo_cnt > 0);
    ev = (fifo_cnt > 0);
    ed = '0; et = '0; el = 1'b0;
    if (ev) begin
      ed = dq_hist[m_wds[0].cap];
      et = m_wds[0].tag;
      el = m_wds[0].last;
    end
    exp_vec = {ev, ed, et, el, ea, eb, m_err};
    s_valid = out_valid; s_data = out_data; s_tag = out_tag; s_last = out_last;
    s_allow = rd_allow; s_busy = busy; s_err = protocol_err;
    obs_vec = {s_valid, s_data, s_tag, s_last, s_allow, s_busy, s_err};
    acc = iss && ea && (cyc - m_last_acc >= BL);
    @(posedge clk);
    if (acc) begin
      lat = eb ? m_lat : int'(clv);
      m_rds.push_back('{t: cyc, lat: lat});
      for (int i = 0; i < BL; i++)
        m_wds.push_back('{vis: cyc + lat + i + 2, cap: cyc + lat + i, tag: tg, last: (i == BL - 1)});
      m_last_acc = cyc;
    end else if (iss) begin
      m_err = 1'b1;
    end
    if (!eb) m_lat = int'(clv);
    if (ev && rdy) void'(m_wds.pop_front());
    while (m_rds.size() > 0 && (m_rds[0].t + m_rds[0].lat + BL < cyc + 1)) void'(m_rds.pop_front());
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; rd_issue = 1'b0; out_ready = 1'b0; cl = 2'd2;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({out_valid, out_data, out_tag, out_last, rd_allow, busy, protocol_err} !== {1'b0, 16'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_values got=%h exp=%h", {out_valid, out_data, out_tag, out_last, rd_allow, busy, protocol_err},
               {1'b0, 16'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0});
    end
  endtask

  task automatic test_single_cl2();
    logic [15:0] pat [4];
    logic [15:0] dv;
    pat[0] = 16'h1111; pat[1] = 16'h2222; pat[2] = 16'h3333; pat[3] = 16'h4444;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      dv = (k >= 2 && k <= 5) ? pat[k-2] : 16'($urandom);
      step(k == 0, 4'd5, 2'd2, 1'b1, dv);
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL single_model k=%0d got=%h exp=%h", k, obs_vec, exp_vec);
      end
      checks++;
      if (k >= 4 && k <= 7) begin
        if ({s_valid, s_data, s_tag, s_last} !== {1'b1, pat[k-4], 4'd5, (k == 7)}) begin
          failures++;
          $display("FAIL single_word k=%0d got=%h exp=%h", k, {s_valid, s_data, s_tag, s_last}, {1'b1, pat[k-4], 4'd5, (k == 7)});
        end
      end else if (s_valid !== 1'b0) begin
        failures++;
        $display("FAIL single_idle k=%0d got=%b exp=0", k, s_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] tg;
    do_reset();
    for (int k = 0; k < 17; k++) begin
      tg = (k == 0) ? 4'd1 : 4'd2;
      step(k == 0 || k == 4, tg, 2'd3, 1'b1, 16'($urandom));
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL b2b_model k=%0d got=%h exp=%h", k, obs_vec, exp_vec);
      end
      checks++;
      if (s_valid !== (k >= 5 && k <= 12) || (s_valid && (s_last !== (k == 8 || k == 12) || s_tag !== ((k < 9) ? 4'd1 : 4'd2)))) begin
        failures++;
        $display("FAIL b2b_timing k=%0d got=v%b l%b t%0d", k, s_valid, s_last, s_tag);
      end
    end
  endtask

  task automatic test_backpressure();
    int n_iss, last_iss, pops;
    bit iss, allow_back;
    do_reset();
    n_iss = 0; last_iss = -100; pops = 0; allow_back = 0;
    for (int k = 0; k < 30; k++) begin
      iss = rd_allow && (k - last_iss >= BL);
      if (iss) begin n_iss++; last_iss = k; end
      step(iss, 4'($urandom), 2'd2, 1'b0, 16'($urandom));
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL bp_fill k=%0d got=%h exp=%h", k, obs_vec, exp_vec);
      end
    end
    checks++;
    if (n_iss !== 2 || rd_allow !== 1'b0) begin
      failures++;
      $display("FAIL bp_accepted got=%0d allow=%b exp=2 allow=0", n_iss, rd_allow);
    end
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 4'd0, 2'd2, 1'b1, 16'($urandom));
      if (s_valid) pops++;
      if (s_valid && s_allow) allow_back = 1;
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL bp_drain k=%0d got=%h exp=%h", k, obs_vec, exp_vec);
      end
    end
    checks++;
    if (pops !== 8 || !allow_back || busy !== 1'b0) begin
      failures++;
      $display("FAIL bp_words got=%0d allow_back=%0d busy=%b exp=8 1 0", pops, allow_back, busy);
    end
  endtask

  task automatic test_protocol_err();
    int pops;
    do_reset();
    pops = 0;
    for (int k = 0; k < 16; k++) begin
      step(k == 0 || k == 2, (k == 0) ? 4'd7 : 4'd8, 2'd2, 1'b1, 16'($urandom));
      if (s_valid) pops++;
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL perr_model k=%0d got=%h exp=%h", k, obs_vec, exp_vec);
      end
      checks++;
      if (s_err !== (k >= 3) || (s_valid && s_tag !== 4'd7)) begin
        failures++;
        $display("FAIL perr_flag k=%0d got=e%b t%0d exp=e%b t7", k, s_err, s_tag, (k >= 3));
      end
    end
    checks++;
    if (pops !== 4) begin
      failures++;
      $display("FAIL perr_words got=%0d exp=4", pops);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 3; k++) step(k == 0, 4'd3, 2'd2, 1'b1, 16'($urandom));
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_data, out_tag, out_last, rd_allow, busy, protocol_err} !== {1'b0, 16'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL rstmid_clear got=%h", {out_valid, out_data, out_tag, out_last, rd_allow, busy, protocol_err});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    for (int k = 0; k < 12; k++) begin
      step(1'b0, 4'd0, 2'd2, 1'b1, 16'($urandom));
      checks++;
      if (s_valid !== 1'b0 || s_busy !== 1'b0 || obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL rstmid_after k=%0d got=v%b b%b exp=v0 b0", k, s_valid, s_busy);
      end
    end
  endtask

  task automatic test_cl_change();
    int first, idle_wait;
    do_reset();
    first = -1;
    for (int k = 0; k < 12; k++) begin
      step(k == 0, 4'd9, (k == 0) ? 2'd2 : 2'd3, 1'b1, 16'($urandom));
      if (s_valid && first < 0) first = k;
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL clchg_model k=%0d got=%h exp=%h", k, obs_vec, exp_vec);
      end
    end
    checks++;
    if (first !== 4) begin
      failures++;
      $display("FAIL clchg_old_lat got=%0d exp=4", first);
    end
    idle_wait = 0;
    while (busy && idle_wait < 50) begin
      step(1'b0, 4'd0, 2'd3, 1'b1, 16'($urandom));
      idle_wait++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL clchg_idle_timeout got=busy%b exp=0", busy);
    end
    first = -1;
    for (int k = 0; k < 12; k++) begin
      step(k == 0, 4'd10, 2'd3, 1'b1, 16'($urandom));
      if (s_valid && first < 0) first = k;
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL clchg_model2 k=%0d got=%h exp=%h", k, obs_vec, exp_vec);
      end
    end
    checks++;
    if (first !== 5) begin
      failures++;
      $display("FAIL clchg_new_lat got=%0d exp=5", first);
    end
  endtask

  task automatic test_random();
    int drain;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      step(($urandom % 3) == 0, 4'($urandom), 2'(2 + ($urandom % 2)), ($urandom % 4) != 0, 16'($urandom));
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL random k=%0d got=%h exp=%h", k, obs_vec, exp_vec);
      end
    end
    drain = 0;
    while ((busy || m_wds.size() > 0) && drain < 60) begin
      step(1'b0, 4'd0, 2'd2, 1'b1, 16'($urandom));
      drain++;
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL random_drain k=%0d got=%h exp=%h", drain, obs_vec, exp_vec);
      end
    end
    checks++;
    if (busy !== 1'b0 || m_wds.size() != 0) begin
      failures++;
      $display("FAIL random_drain_timeout got=busy%b left=%0d exp=0 0", busy, m_wds.size());
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_single_cl2();
    test_back_to_back();
    test_backpressure();
    test_protocol_err();
    test_reset_mid();
    test_cl_change();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdram_rd_return.md
Name: sdram_rd_return

Overview:
- Return-path counterpart to the command-side latency delay lines in the SDRAM controller.
- Tracks each issued read command through a CAS-latency-matched tag pipeline, then captures the BL-word burst from the DQ input bus.
- Buffers the captured words in a small first-word-fall-through FIFO and presents them, with tag and last flag, to the bus side on a valid/ready handshake.

Parameters:
DW, 16, DQ/data width
TW, 4, read tag width
BL, 4, burst length in words (2..8)
CL_MAX, 3, largest supported CAS latency
AW, 3, FIFO address width; depth = 2**AW, must be >= 2*BL

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
cl  in  2  CAS latency, legal 2..CL_MAX
rd_issue  in  1  read command issued to SDRAM this cycle
rd_tag  in  TW  tag of the issued read
rd_allow  out  1  a new read may be issued this cycle
dq_in  in  DW  SDRAM DQ input
out_valid  out  1  output word available
out_data  out  DW  output word
out_tag  out  TW  tag of the burst owning out_data
out_last  out  1  final word of a burst
out_ready  in  1  consumer accepts word when out_valid && out_ready
busy  out  1  read in flight or FIFO non-empty
protocol_err  out  1  sticky: illegal rd_issue seen

Behaviour:
- Reset values: out_valid=0, out_data=0, out_tag=0, out_last=0, busy=0, protocol_err=0, rd_allow=1. Pipeline, burst counter and FIFO pointers are cleared; cl_r loads 2.
- cl_r: loads from cl only in cycles where busy=0. A cl change while busy is held off until idle; in-flight reads keep the old latency.
- Tag pipeline: marker {valid, tag}, CL_MAX stages. rd_issue in cycle T enters stage 1; the tap at stage cl_r fires in cycle T+cl_r.
- Capture window: a tap fire starts a burst counter, BL cycles long, covering cycles T+cl_r .. T+cl_r+BL-1.
  - Each cycle in the window, dq_in is registered into dq_r together with the tag and a last flag (set on count BL-1).
  - The next edge writes that entry to the FIFO.
- Latency: first word has out_valid=1 in cycle T+cl_r+2. Under no backpressure, words follow on consecutive cycles; out_last=1 on the BL-th word.
- Output: FIFO head drives out_data/out_tag/out_last; out_valid = FIFO non-empty. Pop on out_valid && out_ready. Outputs hold stable while out_valid && !out_ready.
- Credit: inflight = BL × (reads issued whose burst is not fully written).
  - rd_allow = (fifo_count + inflight + BL) <= 2**AW, computed combinationally from registered state.
  - Guarantees the FIFO never overflows.
- Spacing: consecutive rd_issue must be >= BL cycles apart. Exactly BL apart yields gapless back-to-back bursts with no bubble between the last and first words.
- Illegal issue: rd_issue while !rd_allow, or fewer than BL cycles after the previous accepted issue.
  - The command is ignored: no marker, no credit.
  - protocol_err is set and stays set until rst.
- FIFO: pointers are AW+1 bits and wrap naturally. Simultaneous push and pop leaves count unchanged. Push to full cannot occur (credit). Pop when empty is not possible (out_valid=0).
- busy = any pipeline marker valid || burst counter active || dq_r valid || FIFO non-empty.
- Reset mid-operation: asynchronous clear of all state. Partially captured bursts are discarded, and no stale words appear after reset release.

Test Plan:
- cl=2, rd_issue@T tag=5, dq_in = 0x1111,0x2222,0x3333,0x4444 in cycles T+2..T+5, out_ready=1 → out_valid in T+4..T+7, those data in order, out_tag=5, out_last only in T+7.
- cl=3, issues tag=1@T and tag=2@T+4 → 8 consecutive output words starting T+5, out_last at T+8 and T+12, tags switch at T+9 with no gap.
- out_ready=0, issue reads whenever rd_allow, AW=3, BL=4 → exactly 2 reads accepted, rd_allow=0 after the 2nd. Release out_ready → rd_allow returns as words drain; no word is lost or duplicated.
- rd_issue 2 cycles after a previous issue (BL=4) → second ignored, protocol_err=1 and sticky. Only the first burst appears, correct data.
- rst asserted at T+3 of a cl=2 read → all outputs 0 immediately. After release with dq_in toggling and no rd_issue, out_valid stays 0 and busy=0.
- cl driven 2→3 one cycle after rd_issue → that burst still uses latency 2. A read issued after busy falls uses latency 3.
